// File: rtl/rv32ima_pkg.sv
// Shared RV32IMA types: operand width, ALU operation codes and M-extension
// multiply operation codes (encoded as funct3[1:0]).
package rv32ima_pkg;

  localparam int unsigned BIT_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } ALUOP_t;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } MULOP_t;

endpackage

// File: rtl/alu_if.sv
// ALU connection bundle.
//   tb  : the client side (the sequential multiplier) drives alu_op/in1/in2 and
//         samples out/carry only.
//   alu : the ALU side drives out and all flags.
interface alu_if;
  import rv32ima_pkg::*;

  ALUOP_t               alu_op;
  logic [BIT_WIDTH-1:0] in1;
  logic [BIT_WIDTH-1:0] in2;
  logic [BIT_WIDTH-1:0] out;
  logic                 carry;
  logic                 zero;
  logic                 neg;
  logic                 overflow;

  modport tb  (output alu_op, in1, in2, input out, carry);
  modport alu (input alu_op, in1, in2, output out, carry, zero, neg, overflow);
endinterface

// File: rtl/alu.sv
// Combinational shared ALU.
// Ports: bus (alu_if.alu) -- alu_op/in1/in2 in; out, carry, zero, neg, overflow out.
// carry is the unsigned carry-out for ADD and the not-borrow for SUB.
module alu
  import rv32ima_pkg::*;
(
  alu_if.alu bus
);

  logic [BIT_WIDTH:0]   sum_c;
  logic [BIT_WIDTH-1:0] res_c;
  logic                 carry_c;
  logic                 ovf_c;

  // Operation decode; one wide adder serves both ADD and SUB.
  always_comb begin
    sum_c   = '0;
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (bus.alu_op)
      ALU_ADD: begin
        sum_c   = {1'b0, bus.in1} + {1'b0, bus.in2};
        res_c   = sum_c[BIT_WIDTH-1:0];
        carry_c = sum_c[BIT_WIDTH];
        ovf_c   = (bus.in1[BIT_WIDTH-1] == bus.in2[BIT_WIDTH-1]) &&
                  (res_c[BIT_WIDTH-1] != bus.in1[BIT_WIDTH-1]);
      end
      ALU_SUB: begin
        sum_c   = {1'b0, bus.in1} + {1'b0, ~bus.in2} + (BIT_WIDTH+1)'(1);
        res_c   = sum_c[BIT_WIDTH-1:0];
        carry_c = sum_c[BIT_WIDTH];
        ovf_c   = (bus.in1[BIT_WIDTH-1] != bus.in2[BIT_WIDTH-1]) &&
                  (res_c[BIT_WIDTH-1] != bus.in1[BIT_WIDTH-1]);
      end
      ALU_AND: res_c = bus.in1 & bus.in2;
      ALU_OR:  res_c = bus.in1 | bus.in2;
      ALU_XOR: res_c = bus.in1 ^ bus.in2;
      default: res_c = '0;
    endcase
  end

  assign bus.out      = res_c;
  assign bus.carry    = carry_c;
  assign bus.zero     = (res_c == '0);
  assign bus.neg      = res_c[BIT_WIDTH-1];
  assign bus.overflow = ovf_c;

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 32x32 shift-add multiplier (RV32M MUL/MULH/MULHSU/MULHU) that
// does all arithmetic through a shared external ALU.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_op, req_a, req_b          operation and operands (rs1, rs2)
//   resp_valid/resp_ready         response handshake, result held until taken
//   resp_result, resp_err         result word, illegal-op flag
//   alu (alu_if.tb)               drives alu_op/in1/in2, samples out/carry
// Macro ALU_MUL_SEQ_SIGNED_EN: when defined, MULH/MULHSU are computed with two
// signed-correction subtractions; when undefined they return resp_err=1.
module alu_mul_seq
  import rv32ima_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  MULOP_t               req_op,
  input  logic [BIT_WIDTH-1:0] req_a,
  input  logic [BIT_WIDTH-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [BIT_WIDTH-1:0] resp_result,
  output logic                 resp_err,
  alu_if.tb                    alu
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ITER   = 3'd1,
    CORR_A = 3'd2,
    CORR_B = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0] hi_q, hi_d;
  logic [BIT_WIDTH-1:0] lo_q, lo_d;
  logic [BIT_WIDTH-1:0] mcand_q, mcand_d;
  MULOP_t               op_q, op_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [BIT_WIDTH-1:0] resp_result_q, resp_result_d;
  logic                 resp_err_q, resp_err_d;
`ifdef ALU_MUL_SEQ_SIGNED_EN
  logic [BIT_WIDTH-1:0] corr_a_q, corr_a_d;
  logic [BIT_WIDTH-1:0] corr_b_q, corr_b_d;
`endif

  // ALU operand steering; kept apart from next-state logic so the ALU
  // round trip is not seen as a loop through one process.
  always_comb begin
    alu.alu_op = ALU_ADD;
    alu.in1    = '0;
    alu.in2    = '0;
    case (state_q)
      ITER: begin
        alu.in1 = hi_q;
        alu.in2 = lo_q[0] ? mcand_q : '0;
      end
`ifdef ALU_MUL_SEQ_SIGNED_EN
      CORR_A: begin
        alu.alu_op = ALU_SUB;
        alu.in1    = hi_q;
        alu.in2    = corr_a_q;
      end
      CORR_B: begin
        alu.alu_op = ALU_SUB;
        alu.in1    = hi_q;
        alu.in2    = corr_b_q;
      end
`endif
      default: ;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    mcand_d       = mcand_q;
    op_d          = op_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_err_d    = resp_err_q;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    corr_a_d      = corr_a_q;
    corr_b_d      = corr_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mcand_d = req_a;
          hi_d    = '0;
          lo_d    = req_b;
          cnt_d   = '0;
          op_d    = req_op;
`ifdef ALU_MUL_SEQ_SIGNED_EN
          // Signed high word = unsigned high word minus these two terms.
          corr_a_d = req_a[BIT_WIDTH-1] ? req_b : '0;
          corr_b_d = (req_op == MULH && req_b[BIT_WIDTH-1]) ? req_a : '0;
          state_d  = ITER;
`else
          if (req_op == MULH || req_op == MULHSU) begin
            state_d       = DONE;
            resp_valid_d  = 1'b1;
            resp_result_d = '0;
            resp_err_d    = 1'b1;
          end else begin
            state_d = ITER;
          end
`endif
        end
      end
      ITER: begin
        // Shift {carry, sum, lo} right by one; the sum's LSB enters lo.
        hi_d  = {alu.carry, alu.out[BIT_WIDTH-1:1]};
        lo_d  = {alu.out[0], lo_q[BIT_WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIT_WIDTH - 1)) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
          if (op_q == MULH || op_q == MULHSU) begin
            state_d = CORR_A;
          end else begin
            state_d       = DONE;
            resp_valid_d  = 1'b1;
            resp_result_d = (op_q == MUL) ? lo_d : hi_d;
            resp_err_d    = 1'b0;
          end
`else
          state_d       = DONE;
          resp_valid_d  = 1'b1;
          resp_result_d = (op_q == MUL) ? lo_d : hi_d;
          resp_err_d    = 1'b0;
`endif
        end
      end
`ifdef ALU_MUL_SEQ_SIGNED_EN
      CORR_A: begin
        hi_d    = alu.out;
        state_d = CORR_B;
      end
      CORR_B: begin
        hi_d          = alu.out;
        state_d       = DONE;
        resp_valid_d  = 1'b1;
        resp_result_d = alu.out;
        resp_err_d    = 1'b0;
      end
`endif
      DONE: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      mcand_q       <= '0;
      op_q          <= MUL;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      corr_a_q      <= '0;
      corr_b_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      mcand_q       <= mcand_d;
      op_q          <= op_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_err_q    <= resp_err_d;
`ifdef ALU_MUL_SEQ_SIGNED_EN
      corr_a_q      <= corr_a_d;
      corr_b_q      <= corr_b_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with the shared ALU instantiated alongside.
module tb_alu_mul_seq;
  import rv32ima_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  MULOP_t      req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_if alu_bus ();

  alu u_alu (.bus(alu_bus));

  alu_mul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_err   (resp_err),
    .alu        (alu_bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge. Issues one request, measures latency from
  // the handshake cycle, optionally stalls resp_ready, then accepts.
  task automatic run_op(input string tag, input MULOP_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_err, input int exp_lat, input int hold);
    int lat;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk); #1;
    // Operands need not be held after the handshake.
    req_valid = 1'b0;
    req_op    = MULHU;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'h0BAD_F00D;
    chk({tag, "_busy"}, 32'(req_ready), 32'd0);
    lat = 1;
    while (!resp_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_result"}, resp_result, exp_res);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_hold_result"}, resp_result, exp_res);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = MUL;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("idle_alu_op", 32'(alu_bus.alu_op), 32'(ALU_ADD));
    chk("idle_in1", alu_bus.in1, 32'd0);
    chk("idle_in2", alu_bus.in2, 32'd0);

    run_op("mul_7x6",   MUL,   32'd7,        32'd6,        32'h0000_002A, 1'b0, 33, 0);
    run_op("mulhu_ff",  MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 0);
    run_op("mul_ff",    MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33, 0);
    run_op("mul_2p32",  MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 33, 0);
    run_op("mulhu_2p32", MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 33, 0);

`ifdef ALU_MUL_SEQ_SIGNED_EN
    run_op("mulh_min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 35, 0);
    run_op("mulh_m1",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 35, 0);
    run_op("mulhsu_ff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 35, 0);
`else
    run_op("mulh_min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1, 0);
    run_op("mulh_m1",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 0);
    run_op("mulhsu_ff", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1, 0);
`endif
    // A normal request after an error response still works.
    run_op("mul_after", MUL, 32'd12, 32'd11, 32'd132, 1'b0, 33, 0);

    // Consumer stalls for 5 cycles.
    run_op("hold", MUL, 32'h0000_0100, 32'h0000_0100, 32'h0001_0000, 1'b0, 33, 5);

    // Reset in the middle of ITER, after 10 iterations.
    req_valid = 1'b1;
    req_op    = MUL;
    req_a     = 32'h0000_1234;
    req_b     = 32'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(resp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_in1", alu_bus.in1, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("midrst_no_resp", 32'(seen), 32'd0);
    run_op("mul_3x5", MUL, 32'd3, 32'd5, 32'd15, 1'b0, 33, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have clock port clk: one clock, all state on its rising edge.
REQ-002 SHALL have reset port rst: asynchronous, active-high.
REQ-003 SHALL have `req_valid  in  1`: a multiply request is present.
REQ-004 SHALL have `req_ready  out  1`: block accepts a request; high only in IDLE.
REQ-005 SHALL have `req_op  in  MULOP_t (2)`: operation select, one of MUL, MULH, MULHSU, MULHU.
REQ-006 SHALL have `req_a`, `req_b`  in  BIT_WIDTH: the operands (a = rs1, b = rs2).
REQ-007 SHALL have `resp_valid  out  1`: the result is held stable.
REQ-008 SHALL have `resp_ready  in  1`: the consumer accepts the result.
REQ-009 SHALL have `resp_result  out  BIT_WIDTH` and `resp_err  out  1`: result word and illegal-op flag.
REQ-010 SHALL connect to the ALU through an alu_if tb modport.
- Drives alu_op, in1, in2.
- Samples out and carry.
- Ignores zero, neg, overflow.

Function
REQ-011 SHALL implement the FSM states IDLE, ITER, CORR_A, CORR_B, DONE.
REQ-012 SHALL act on a handshake (req_valid && req_ready) in IDLE as follows:
- Load mcand=a, hi=0, lo=b, cnt=0, latch op and the correction terms.
- Go to ITER.
REQ-013 In ITER, SHALL drive alu_op=ALU_ADD, in1=hi, in2=(lo[0] ? mcand : 0).
- Update hi <= {carry, out[31:1]} and lo <= {out[0], lo[31:1]}.
- Increment cnt.
REQ-014 SHALL leave ITER after exactly 32 cycles (cnt wraps 31->0).
- MUL/MULHU go to DONE.
- MULH/MULHSU go to CORR_A.
REQ-015 In CORR_A, SHALL drive alu_op=ALU_SUB, in1=hi, in2=corr_a, hi <= out; then go to CORR_B.
- corr_a = (a[31] ? b : 0).
REQ-016 In CORR_B, SHALL drive alu_op=ALU_SUB, in1=hi, in2=corr_b, hi <= out; then go to DONE.
- corr_b = (op==MULH && b[31]) ? a : 0.
REQ-017 In DONE, SHALL assert resp_valid with resp_result as follows:
- resp_result = lo for MUL.
- resp_result = hi otherwise.
- resp_err = 0.
REQ-018 SHALL hold resp_valid/result/err stable until resp_ready, then return to IDLE in the next cycle.
- There is no same-cycle re-accept.
REQ-019 SHALL have fixed latency: handshake in cycle T gives resp_valid in T+33 (MUL, MULHU) or T+35 (MULH, MULHSU).
REQ-020 Outside ITER/CORR_*, SHALL drive alu_op=ALU_ADD, in1=0, in2=0.
REQ-021 SHALL compute all arithmetic through the ALU.
- No local adders except the 5-bit cnt.
- ALU_ADD carry SHALL be taken as the unsigned carry-out.
REQ-022 SHALL ignore req_valid while not in IDLE; request inputs need not be held after the handshake.

Reset
REQ-023 On rst, SHALL asynchronously force the following, aborting any operation in flight with no response:
- state=IDLE.
- cnt=0.
- hi=lo=mcand=0.
- resp_valid=0, resp_result=0, resp_err=0.
REQ-024 SHALL assert req_ready in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL use the macro ALU_MUL_SEQ_SIGNED_EN to select signed support.
- Defined: MULH and MULHSU behave per REQ-015/016.
- Undefined: CORR_A/CORR_B are not built, and MULH/MULHSU requests are accepted, then go straight to DONE next cycle with resp_err=1 and resp_result=0 (resp_valid at T+1).
- MUL/MULHU are identical in both builds.

Structure
REQ-026 SHALL place MULOP_t in rv32ima_pkg, encoded per funct3: MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11.
REQ-027 SHALL place the FSM state enum locally in the module.
REQ-028 SHALL reuse ALUOP_t values ALU_ADD/ALU_SUB and BIT_WIDTH from rv32ima_pkg.
REQ-029 SHALL have no sub-module; the ALU is instantiated externally and shared through alu_if.

Verification
REQ-030 Bench SHALL cover the following directed scenarios, ALU instantiated alongside:
- MUL a=7, b=6 -> result 0x0000002A at T+33, err=0.
- MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
- MULH a=b=0x80000000 -> 0x40000000; MULH a=b=0xFFFFFFFF -> 0x00000000, each at T+35.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- Built without the macro: MULHSU -> resp_err=1, result 0 at T+1.
- resp_ready low 5 cycles after resp_valid -> result stable, req_ready low throughout, IDLE one cycle after accept.
- rst pulsed mid-ITER (cnt=10) -> resp_valid=0 and state IDLE immediately; next MUL 3*5 -> 15.
